// File: rtl/axil_regbank.sv
// axil_regbank: AXI4-Lite slave register bank with per-register read-only mirroring.
//
// Parameters
//   DATA_WIDTH  AXI data width (32 or 64)
//   NUM_REGS    number of registers (1..256)
//   ADDR_WIDTH  byte-address width
//   RO_MASK     bit i set: register i is read-only and mirrors status_d
//
// Ports
//   ACLK, ARESETN        clock, synchronous active-low reset
//   S_AXI_AW*/W*/B*      write address, write data, write response channels
//   S_AXI_AR*/R*         read address and read data channels
//   reg_q                flat register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_wr_pulse         one-cycle pulse per committed register write
//   status_d             hardware values shown by the read-only registers
module axil_regbank #(
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         NUM_REGS   = 4,
  parameter int unsigned         ADDR_WIDTH = 12,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_d
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam int unsigned SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // Write-side hold registers
  logic                  aw_held, w_held;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  logic                  aw_hs, w_hs, ar_hs, commit, wr_oor, wr_ok, rd_oor;
  logic                  aw_held_n, w_held_n, bvalid_n, rvalid_n;
  logic [IDX_W-1:0]      rd_idx;
  logic [SEL_W-1:0]      rd_sel;
  logic [NUM_REGS-1:0]   wr_sel;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic [DATA_WIDTH-1:0] rd_src [NUM_REGS];

  // Byte-offset address bits carry no information for word-wide registers
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  // Handshakes, commit decision and decode
  always_comb begin
    aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
    w_hs   = S_AXI_WVALID & S_AXI_WREADY;
    ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
    commit = aw_held & w_held & ~S_AXI_BVALID;
    wr_oor = 32'(aw_idx_q) >= NUM_REGS;
    wr_ok  = commit & ~wr_oor & ~(|(wr_sel & RO_MASK));
    rd_idx = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
    rd_sel = SEL_W'(rd_idx);
    rd_oor = 32'(rd_idx) >= NUM_REGS;
    rd_data_c = rd_oor ? '0 : rd_src[rd_sel];
  end

  // Next-state for hold flags and response valids
  always_comb begin
    aw_held_n = aw_held;
    w_held_n  = w_held;
    bvalid_n  = S_AXI_BVALID;
    rvalid_n  = S_AXI_RVALID;
    if (commit) begin
      aw_held_n = 1'b0;
      w_held_n  = 1'b0;
    end else begin
      if (aw_hs) aw_held_n = 1'b1;
      if (w_hs)  w_held_n  = 1'b1;
    end
    if (S_AXI_BVALID && S_AXI_BREADY) bvalid_n = 1'b0;
    if (commit)                       bvalid_n = 1'b1;
    if (S_AXI_RVALID && S_AXI_RREADY) rvalid_n = 1'b0;
    if (ar_hs)                        rvalid_n = 1'b1;
  end

  // Channel state, responses and write pulses
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx_q      <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
      reg_wr_pulse  <= '0;
    end else begin
      aw_held       <= aw_held_n;
      w_held        <= w_held_n;
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      S_AXI_AWREADY <= ~aw_held_n;
      S_AXI_WREADY  <= ~w_held_n;
      S_AXI_BVALID  <= bvalid_n;
      if (commit) S_AXI_BRESP <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      reg_wr_pulse  <= wr_ok ? wr_sel : '0;
      S_AXI_ARREADY <= ~rvalid_n;
      S_AXI_RVALID  <= rvalid_n;
      if (ar_hs) begin
        S_AXI_RDATA <= rd_data_c;
        S_AXI_RRESP <= rd_oor ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Strobe bytes expanded to a bit mask
  for (genvar b = 0; b < STRB_W; b++) begin : g_mask
    assign wr_mask[b*8 +: 8] = {8{w_strb_q[b]}};
  end

  // Per-register storage: RO entries mirror status_d, RW entries take strobed writes
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    logic [DATA_WIDTH-1:0] q;

    assign wr_sel[g] = (32'(aw_idx_q) == 32'(g));
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = q;

    if (RO_MASK[g]) begin : g_ro
      assign rd_src[g] = status_d[g*DATA_WIDTH +: DATA_WIDTH];
      always_ff @(posedge ACLK) begin
        if (!ARESETN) q <= '0;
        else          q <= status_d[g*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin : g_rw
      logic unused_status;
      assign unused_status = ^status_d[g*DATA_WIDTH +: DATA_WIDTH];
      assign rd_src[g] = q;
      always_ff @(posedge ACLK) begin
        if (!ARESETN)                q <= '0;
        else if (wr_ok && wr_sel[g]) q <= (q & ~wr_mask) | (w_data_q & wr_mask);
      end
    end
  end

endmodule
